// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module  : alu_ctrl_pkg
// Brief   : Shared encodings for the multi-cycle ALU controller: ALU op codes,
//           R-type func codes, mult/div and HI/LO selects, sequencer states.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

    // ALU operation codes (4-bit core, zero-extended to OP_W at the port)
    localparam logic [3:0] c_alu_and  = 4'b0000;
    localparam logic [3:0] c_alu_or   = 4'b0001;
    localparam logic [3:0] c_alu_add  = 4'b0010;
    localparam logic [3:0] c_alu_xor  = 4'b0011;
    localparam logic [3:0] c_alu_nor  = 4'b0100;
    localparam logic [3:0] c_alu_sltu = 4'b0101;
    localparam logic [3:0] c_alu_sub  = 4'b0110;
    localparam logic [3:0] c_alu_slt  = 4'b0111;
    localparam logic [3:0] c_alu_sll  = 4'b1000;
    localparam logic [3:0] c_alu_srl  = 4'b1001;
    localparam logic [3:0] c_alu_sra  = 4'b1010;

    // Main-control alu_op field
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_rtype = 2'b10;
    localparam logic [1:0] c_aluop_and   = 2'b11;

    // R-type func field
    localparam logic [5:0] c_fn_add   = 6'b100000;
    localparam logic [5:0] c_fn_addu  = 6'b100001;
    localparam logic [5:0] c_fn_sub   = 6'b100010;
    localparam logic [5:0] c_fn_subu  = 6'b100011;
    localparam logic [5:0] c_fn_and   = 6'b100100;
    localparam logic [5:0] c_fn_or    = 6'b100101;
    localparam logic [5:0] c_fn_xor   = 6'b100110;
    localparam logic [5:0] c_fn_nor   = 6'b100111;
    localparam logic [5:0] c_fn_slt   = 6'b101010;
    localparam logic [5:0] c_fn_sltu  = 6'b101011;
    localparam logic [5:0] c_fn_sll   = 6'b000000;
    localparam logic [5:0] c_fn_srl   = 6'b000010;
    localparam logic [5:0] c_fn_sra   = 6'b000011;
    localparam logic [5:0] c_fn_mfhi  = 6'b010000;
    localparam logic [5:0] c_fn_mflo  = 6'b010010;
    localparam logic [5:0] c_fn_mult  = 6'b011000;
    localparam logic [5:0] c_fn_multu = 6'b011001;
    localparam logic [5:0] c_fn_div   = 6'b011010;
    localparam logic [5:0] c_fn_divu  = 6'b011011;

    // Mult/div datapath operation
    localparam logic [1:0] c_md_mult  = 2'b00;
    localparam logic [1:0] c_md_multu = 2'b01;
    localparam logic [1:0] c_md_div   = 2'b10;
    localparam logic [1:0] c_md_divu  = 2'b11;

    // Result source select
    localparam logic [1:0] c_hilo_alu = 2'b00;
    localparam logic [1:0] c_hilo_hi  = 2'b01;
    localparam logic [1:0] c_hilo_lo  = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_mc_md_seq.sv
// ============================================================================
// Module  : md_seq
// Brief   : Mult/div sequencer: start pulse, counted stall window, done pulse,
//           with flush abort.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module md_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       flush,
    input  logic [1:0] op,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       stall,
    output logic       md_done
);

    localparam int CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

    md_state_t        r_state;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            md_start <= 1'b0;
            md_op    <= 2'b00;
            stall    <= 1'b0;
            md_done  <= 1'b0;
        end else begin
            md_start <= 1'b0;
            md_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // start arrives already qualified by issue and !flush
                    if (start) begin
                        r_state  <= S_BUSY;
                        r_count  <= CNT_W'(MD_CYCLES - 1);
                        md_start <= 1'b1;
                        md_op    <= op;
                        stall    <= 1'b1;
                    end else begin
                        stall    <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        stall   <= 1'b0;
                    end else if (r_count == '0) begin
                        r_state <= S_IDLE;
                        stall   <= 1'b0;
                        md_done <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                        stall   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                    stall   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_mc.sv
// ============================================================================
// Module  : alu_ctrl_mc
// Brief   : EX-stage ALU controller: registered alu_op/func decode plus
//           mult/div sequencing and HI/LO read select.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_ctrl_mc
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W      = 4,
    parameter int FUNC_W    = 6,
    parameter int MD_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              flush,
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] func,
    output logic [OP_W-1:0]   alu_operation,
    output logic              md_start,
    output logic [1:0]        md_op,
    output logic              stall,
    output logic              md_done,
    output logic [1:0]        hilo_sel,
    output logic              illegal
);

    logic [3:0] w_code;
    logic [1:0] w_hilo;
    logic       w_illegal;
    logic       w_is_md;
    logic [1:0] w_md_op;
    logic       w_accept;

    always_comb begin
        w_code    = c_alu_add;
        w_hilo    = c_hilo_alu;
        w_illegal = 1'b0;
        w_is_md   = 1'b0;
        w_md_op   = c_md_mult;
        case (alu_op)
            c_aluop_add: w_code = c_alu_add;
            c_aluop_sub: w_code = c_alu_sub;
            c_aluop_and: w_code = c_alu_and;
            c_aluop_rtype: begin
                case (func)
                    c_fn_add, c_fn_addu: w_code = c_alu_add;
                    c_fn_sub, c_fn_subu: w_code = c_alu_sub;
                    c_fn_and:            w_code = c_alu_and;
                    c_fn_or:             w_code = c_alu_or;
                    c_fn_xor:            w_code = c_alu_xor;
                    c_fn_nor:            w_code = c_alu_nor;
                    c_fn_slt:            w_code = c_alu_slt;
                    c_fn_sltu:           w_code = c_alu_sltu;
                    c_fn_sll:            w_code = c_alu_sll;
                    c_fn_srl:            w_code = c_alu_srl;
                    c_fn_sra:            w_code = c_alu_sra;
                    c_fn_mfhi:           w_hilo = c_hilo_hi;
                    c_fn_mflo:           w_hilo = c_hilo_lo;
                    c_fn_mult:  begin w_is_md = 1'b1; w_md_op = c_md_mult;  end
                    c_fn_multu: begin w_is_md = 1'b1; w_md_op = c_md_multu; end
                    c_fn_div:   begin w_is_md = 1'b1; w_md_op = c_md_div;   end
                    c_fn_divu:  begin w_is_md = 1'b1; w_md_op = c_md_divu;  end
                    default:             w_illegal = 1'b1;
                endcase
            end
            default: w_code = c_alu_add;
        endcase
    end

    // stall mirrors the sequencer's BUSY state, so issues under stall are dropped
    assign w_accept = issue && !flush && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_operation <= '0;
            hilo_sel      <= 2'b00;
            illegal       <= 1'b0;
        end else begin
            hilo_sel <= c_hilo_alu;
            illegal  <= 1'b0;
            if (w_accept) begin
                alu_operation <= OP_W'(w_code);
                hilo_sel      <= w_hilo;
                illegal       <= w_illegal;
            end
        end
    end

    md_seq #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (w_accept && w_is_md),
        .flush    (flush),
        .op       (w_md_op),
        .md_start (md_start),
        .md_op    (md_op),
        .stall    (stall),
        .md_done  (md_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_mc.sv
// ============================================================================
// Module  : tb_alu_ctrl_mc
// Brief   : Self-checking bench for alu_ctrl_mc: decode table, mult/div timing
//           sequences, flush/reset corners and randomized traffic.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_ctrl_mc;

    localparam int MD_CYCLES = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue;
    logic       flush;
    logic [1:0] alu_op;
    logic [5:0] func;
    logic [3:0] alu_operation;
    logic       md_start;
    logic [1:0] md_op;
    logic       stall;
    logic       md_done;
    logic [1:0] hilo_sel;
    logic       illegal;

    alu_ctrl_mc #(.OP_W(4), .FUNC_W(6), .MD_CYCLES(MD_CYCLES)) dut (
        .clk(clk), .rst(rst), .issue(issue), .flush(flush), .alu_op(alu_op),
        .func(func), .alu_operation(alu_operation), .md_start(md_start),
        .md_op(md_op), .stall(stall), .md_done(md_done), .hilo_sel(hilo_sel),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: timeline of absolute cycle numbers
    int         cyc;
    int         md_end;   // last cycle with stall expected
    int         done_at;  // cycle where md_done is expected
    logic [3:0] e_code;
    logic [1:0] e_mdop;
    logic [1:0] e_hilo;
    logic       e_ill;
    logic       e_start;
    logic       e_stall;
    logic       e_done;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] code;
        logic [1:0] hs;
        logic       ill;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] legal_fn[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                       output logic [3:0] code, output logic [1:0] hs,
                                       output logic ill, output logic md);
        code = 4'b0010; hs = 2'b00; ill = 1'b0; md = 1'b0;
        if (op == 2'b01) code = 4'b0110;
        else if (op == 2'b11) code = 4'b0000;
        else if (op == 2'b10) begin
            case (fn)
                6'b100000, 6'b100001: code = 4'b0010;
                6'b100010, 6'b100011: code = 4'b0110;
                6'b100100: code = 4'b0000;
                6'b100101: code = 4'b0001;
                6'b100110: code = 4'b0011;
                6'b100111: code = 4'b0100;
                6'b101010: code = 4'b0111;
                6'b101011: code = 4'b0101;
                6'b000000: code = 4'b1000;
                6'b000010: code = 4'b1001;
                6'b000011: code = 4'b1010;
                6'b010000: hs = 2'b01;
                6'b010010: hs = 2'b10;
                6'b011000, 6'b011001, 6'b011010, 6'b011011: md = 1'b1;
                default: ill = 1'b1;
            endcase
        end
    endfunction

    task automatic model_reset();
        md_end = -1; done_at = -1;
        e_code = 4'd0; e_mdop = 2'd0; e_hilo = 2'd0;
        e_ill = 1'b0; e_start = 1'b0; e_stall = 1'b0; e_done = 1'b0;
    endtask

    task automatic model_step(input logic i, input logic f, input logic [1:0] op,
                              input logic [5:0] fn);
        logic       busy_now;
        logic [3:0] code;
        logic [1:0] hs;
        logic       ill;
        logic       md;
        busy_now = (cyc <= md_end);
        e_start = 1'b0; e_hilo = 2'b00; e_ill = 1'b0;
        if (busy_now && f) begin
            md_end  = cyc;
            done_at = -1;
        end else if (!busy_now && i && !f) begin
            ref_decode(op, fn, code, hs, ill, md);
            e_code = code; e_hilo = hs; e_ill = ill;
            if (md) begin
                e_start = 1'b1;
                e_mdop  = fn[1:0];
                md_end  = cyc + MD_CYCLES;
                done_at = cyc + MD_CYCLES + 1;
            end
        end
        cyc++;
        e_stall = (cyc <= md_end);
        e_done  = (cyc == done_at);
    endtask

    task automatic check_all();
        chk("alu_operation", alu_operation, e_code);
        chk("md_start", md_start, e_start);
        chk("md_op", md_op, e_mdop);
        chk("stall", stall, e_stall);
        chk("md_done", md_done, e_done);
        chk("hilo_sel", hilo_sel, e_hilo);
        chk("illegal", illegal, e_ill);
    endtask

    task automatic step(input logic i, input logic f, input logic [1:0] op, input logic [5:0] fn);
        issue = i; flush = f; alu_op = op; func = fn;
        @(posedge clk);
        #1;
        model_step(i, f, op, fn);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'b00, 6'b000000);
    endtask

    initial begin
        int seen_done;
        rst = 1'b1; issue = 1'b0; flush = 1'b0; alu_op = 2'b00; func = 6'b0;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // decode table
        vecs.push_back('{2'b00, 6'b100100, 4'b0010, 2'b00, 1'b0});
        vecs.push_back('{2'b01, 6'b100000, 4'b0110, 2'b00, 1'b0});
        vecs.push_back('{2'b11, 6'b100101, 4'b0000, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b100000, 4'b0010, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b100001, 4'b0010, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b100010, 4'b0110, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b100011, 4'b0110, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b100100, 4'b0000, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b100101, 4'b0001, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b100110, 4'b0011, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b100111, 4'b0100, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b101010, 4'b0111, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b101011, 4'b0101, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b000000, 4'b1000, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b000010, 4'b1001, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b000011, 4'b1010, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b010000, 4'b0010, 2'b01, 1'b0});
        vecs.push_back('{2'b11, 6'b000000, 4'b0000, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 6'b010010, 4'b0010, 2'b10, 1'b0});
        vecs.push_back('{2'b10, 6'b111111, 4'b0010, 2'b00, 1'b1});
        vecs.push_back('{2'b10, 6'b000001, 4'b0010, 2'b00, 1'b1});
        for (int v = 0; v < vecs.size(); v++) begin
            step(1'b1, 1'b0, vecs[v].op, vecs[v].fn);
            chk("vec_code", alu_operation, vecs[v].code);
            chk("vec_hilo", hilo_sel, vecs[v].hs);
            chk("vec_illegal", illegal, vecs[v].ill);
        end

        // illegal is a single-cycle pulse, code holds
        step(1'b1, 1'b0, 2'b10, 6'b111111);
        chk("illegal_pulse", illegal, 1'b1);
        step(1'b0, 1'b0, 2'b10, 6'b111111);
        chk("illegal_cleared", illegal, 1'b0);
        chk("illegal_code_hold", alu_operation, 4'b0010);

        // flush in IDLE drops the issue
        step(1'b1, 1'b1, 2'b10, 6'b010010);
        chk("flush_idle_hilo", hilo_sel, 2'b00);
        step(1'b1, 1'b1, 2'b10, 6'b011000);
        chk("flush_idle_nostart", md_start, 1'b0);

        // mult with issue held high through the stall window
        step(1'b1, 1'b0, 2'b10, 6'b011000);
        chk("mult_start", md_start, 1'b1);
        chk("mult_op", md_op, 2'b00);
        for (int k = 0; k < MD_CYCLES; k++) begin
            chk("mult_stall_window", stall, 1'b1);
            chk("mult_no_early_done", md_done, 1'b0);
            step(1'b1, 1'b0, 2'b10, 6'b011000);
        end
        chk("mult_done", md_done, 1'b1);
        chk("mult_stall_low", stall, 1'b0);
        idle(2);

        // divu then add on the md_done cycle
        step(1'b1, 1'b0, 2'b10, 6'b011011);
        idle(MD_CYCLES);
        chk("divu_done", md_done, 1'b1);
        step(1'b1, 1'b0, 2'b10, 6'b100000);
        chk("b2b_code", alu_operation, 4'b0010);
        chk("b2b_mdop", md_op, 2'b11);
        chk("b2b_nostall", stall, 1'b0);

        // flush at cycle 10 of a div
        step(1'b1, 1'b0, 2'b10, 6'b011010);
        idle(9);
        step(1'b0, 1'b1, 2'b00, 6'b000000);
        chk("flush_busy_stall", stall, 1'b0);
        seen_done = 0;
        for (int k = 0; k < MD_CYCLES + 4; k++) begin
            step(1'b0, 1'b0, 2'b00, 6'b000000);
            if (md_done) seen_done++;
        end
        chk("flush_no_done", seen_done, 0);
        step(1'b1, 1'b0, 2'b10, 6'b011000);
        idle(MD_CYCLES);
        chk("post_flush_full_run", md_done, 1'b1);

        // async reset mid-BUSY, between edges
        step(1'b1, 1'b0, 2'b10, 6'b011001);
        idle(5);
        issue = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_stall", stall, 1'b0);
        chk("arst_mdop", md_op, 2'b00);
        chk("arst_code", alu_operation, 4'b0000);
        chk("arst_done", md_done, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 2'b01, 6'b000000);
        chk("arst_after_sub", alu_operation, 4'b0110);
        chk("arst_no_done", md_done, 1'b0);

        // randomized traffic against the model
        legal_fn = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                     6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                     6'b000011, 6'b010000, 6'b010010, 6'b011000, 6'b011001, 6'b011010,
                     6'b011011};
        for (int k = 0; k < 1500; k++) begin
            logic [5:0] fn;
            if ($urandom_range(0, 3) != 0) fn = legal_fn[$urandom_range(0, legal_fn.size() - 1)];
            else fn = 6'($urandom);
            step(1'($urandom), ($urandom_range(0, 15) == 0), 2'($urandom), fn);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
